// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the issue-side hazard scoreboard.
// forw_mux is the operand-select encoding the EX operand muxes decode.
// rv32i_types carries the shadow-slot record and the source-match helpers.
package forw_mux;
    typedef enum logic [1:0] {
        idex_rs1reg_out  = 2'b00,
        exmem_alureg_out = 2'b01,
        regfile_wdata    = 2'b10
    } forw_mux_sel_t;

    // rs2 uses the same "take the ID/EX register value" encoding as rs1.
    localparam forw_mux_sel_t idex_rs2reg_out = idex_rs1reg_out;
endpackage

package rv32i_types;
    import forw_mux::*;

    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;
    localparam int CNT_W    = 2;

    // rd is stored as 0 for non-writers, so a slot only ever matches real writers.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] rd;
        logic             is_load;
    } hz_slot_t;

    function automatic logic slot_match(input hz_slot_t s, input logic use_rs,
                                        input logic [IDX_W-1:0] rs);
        return s.valid && use_rs && (rs != '0) && (s.rd == rs);
    endfunction

    // Youngest in-flight writer wins; WB needs no bypass (write-before-read regfile).
    function automatic forw_mux_sel_t fwd_pick(input hz_slot_t ex, input hz_slot_t mem,
                                               input logic use_rs,
                                               input logic [IDX_W-1:0] rs);
        if (slot_match(ex, use_rs, rs))       return exmem_alureg_out;
        else if (slot_match(mem, use_rs, rs)) return regfile_wdata;
        else                                  return idex_rs1reg_out;
    endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> scoreboard bundle: ID issue info, WB retirement, and hazard results.
interface hazard_scoreboard_if;
    import rv32i_types::*;
    import forw_mux::*;

    logic                pipe_freeze;
    logic                id_flush;
    logic                id_valid;
    logic [IDX_W-1:0]    id_rs1;
    logic [IDX_W-1:0]    id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic [IDX_W-1:0]    id_rd;
    logic                id_regfile_ld;
    logic                id_is_load;
    logic                wb_retire;
    logic [IDX_W-1:0]    wb_rd;
    logic                wb_regfile_ld;
    logic                load_use_stall;
    forw_mux_sel_t       rs1_fwd_sel;
    forw_mux_sel_t       rs2_fwd_sel;
    logic [NUM_REGS-1:0] pending_mask;
    logic                sb_err;

    modport master (
        output pipe_freeze, id_flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regfile_ld, id_is_load, wb_retire, wb_rd, wb_regfile_ld,
        input  load_use_stall, rs1_fwd_sel, rs2_fwd_sel, pending_mask, sb_err
    );

    modport slave (
        input  pipe_freeze, id_flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regfile_ld, id_is_load, wb_retire, wb_rd, wb_regfile_ld,
        output load_use_stall, rs1_fwd_sel, rs2_fwd_sel, pending_mask, sb_err
    );
endinterface

// File: rtl/hazard_slot_pipe.sv
// Shadow copy of the EX/MEM/WB occupants; advances with the real pipeline.
module hazard_slot_pipe
    import rv32i_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     advance,
    input  hz_slot_t slot_in,
    output hz_slot_t ex_slot,
    output hz_slot_t mem_slot,
    output hz_slot_t wb_slot
);
    hz_slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;

    // Shift one stage when the pipeline moves, otherwise hold.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (advance) begin
            ex_d  = slot_in;
            mem_d = ex_q;
            wb_d  = mem_q;
        end
    end

    // Slot registers; reset drops every in-flight entry at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_slot  = ex_q;
    assign mem_slot = mem_q;
    assign wb_slot  = wb_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard source: load-use stall, registered forwarding selects,
// per-register pending-writer counts and a sticky consistency checker.
module hazard_scoreboard
    import rv32i_types::*, forw_mux::*;
(
    input  logic clk,
    input  logic rst,
    hazard_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_slot_t ex_slot, mem_slot, wb_slot, slot_in;
    logic id_live, id_writer, issue, stall, dec_en;
    forw_mux_sel_t rs1_sel_q, rs1_sel_d, rs2_sel_q, rs2_sel_d;
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_REGS-1:0] pend;
    logic err_q, err_d;
    logic unused_slot_bits;

    assign id_live   = sb.id_valid && !sb.id_flush;
    assign id_writer = sb.id_regfile_ld && (sb.id_rd != '0);
    assign stall     = id_live && ex_slot.is_load &&
                       (slot_match(ex_slot, sb.id_use_rs1, sb.id_rs1) ||
                        slot_match(ex_slot, sb.id_use_rs2, sb.id_rs2));
    assign issue     = id_live && !stall && !sb.pipe_freeze;
    assign dec_en    = sb.wb_retire && !sb.pipe_freeze && sb.wb_regfile_ld &&
                       (sb.wb_rd != '0);

    // Record entering EX: the issued instruction or a bubble.
    always_comb begin
        slot_in = '0;
        if (issue) begin
            slot_in.valid   = 1'b1;
            slot_in.rd      = id_writer ? sb.id_rd : '0;
            slot_in.is_load = id_writer && sb.id_is_load;
        end
    end

    hazard_slot_pipe u_slots (
        .clk      (clk),
        .rst      (rst),
        .advance  (!sb.pipe_freeze),
        .slot_in  (slot_in),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot)
    );

    // Selects follow the instruction into EX; bubbles read the register value.
    always_comb begin
        rs1_sel_d = rs1_sel_q;
        rs2_sel_d = rs2_sel_q;
        if (!sb.pipe_freeze) begin
            rs1_sel_d = idex_rs1reg_out;
            rs2_sel_d = idex_rs2reg_out;
            if (issue) begin
                rs1_sel_d = fwd_pick(ex_slot, mem_slot, sb.id_use_rs1, sb.id_rs1);
                rs2_sel_d = fwd_pick(ex_slot, mem_slot, sb.id_use_rs2, sb.id_rs2);
            end
        end
    end

    // Pending counters plus underflow/overflow and WB shadow checks.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        pend  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            logic inc, dec;
            inc = issue && id_writer && (sb.id_rd == IDX_W'(r));
            dec = dec_en && (sb.wb_rd == IDX_W'(r));
            if (inc && !dec) begin
                if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec && !inc) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - 1'b1;
            end
            pend[r] = (cnt_q[r] != '0);
        end
        if (sb.wb_retire &&
            (!wb_slot.valid || (sb.wb_regfile_ld && (wb_slot.rd != sb.wb_rd))))
            err_d = 1'b1;
    end

    // Select, counter and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_sel_q <= idex_rs1reg_out;
            rs2_sel_q <= idex_rs2reg_out;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            rs1_sel_q <= rs1_sel_d;
            rs2_sel_q <= rs2_sel_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign unused_slot_bits  = mem_slot.is_load ^ wb_slot.is_load;

    assign sb.load_use_stall = stall;
    assign sb.rs1_fwd_sel    = rs1_sel_q;
    assign sb.rs2_fwd_sel    = rs2_sel_q;
    assign sb.pending_mask   = pend;
    assign sb.sb_err         = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a cycle table of instruction-stream
// vectors followed by freeze, checker and reset sequences.
module tb_hazard_scoreboard;
    import forw_mux::*;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if sb_if();

    hazard_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

    typedef struct {
        logic v, fl, fz;
        logic [4:0] rs1; logic u1;
        logic [4:0] rs2; logic u2;
        logic [4:0] rd;  logic ld, isl;
        logic wr; logic [4:0] wrd;
        logic st;
        forw_mux_sel_t s1, s2;
        logic [31:0] mask;
        logic err;
    } vec_t;

    localparam forw_mux_sel_t I = idex_rs1reg_out;
    localparam forw_mux_sel_t E = exmem_alureg_out;
    localparam forw_mux_sel_t W = regfile_wdata;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[33];
    vec_t t;

    function automatic vec_t mk(input int v, fl, fz, rs1, u1, rs2, u2, rd, ld, isl,
                                wr, wrd, st, input forw_mux_sel_t s1, s2,
                                input logic [31:0] m);
        vec_t r;
        r.v = (v != 0); r.fl = (fl != 0); r.fz = (fz != 0);
        r.rs1 = 5'(rs1); r.u1 = (u1 != 0);
        r.rs2 = 5'(rs2); r.u2 = (u2 != 0);
        r.rd = 5'(rd); r.ld = (ld != 0); r.isl = (isl != 0);
        r.wr = (wr != 0); r.wrd = 5'(wrd);
        r.st = (st != 0); r.s1 = s1; r.s2 = s2; r.mask = m; r.err = 1'b0;
        return r;
    endfunction

    function automatic vec_t idl(input int wr, wrd, input logic [31:0] m);
        return mk(0,0,0, 0,0, 0,0, 0,0,0, wr,wrd, 0, I,I, m);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        sb_if.id_valid      = v.v;
        sb_if.id_flush      = v.fl;
        sb_if.pipe_freeze   = v.fz;
        sb_if.id_rs1        = v.rs1;
        sb_if.id_use_rs1    = v.u1;
        sb_if.id_rs2        = v.rs2;
        sb_if.id_use_rs2    = v.u2;
        sb_if.id_rd         = v.rd;
        sb_if.id_regfile_ld = v.ld;
        sb_if.id_is_load    = v.isl;
        sb_if.wb_retire     = v.wr;
        sb_if.wb_rd         = v.wrd;
        sb_if.wb_regfile_ld = v.wr;
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, " stall"}, 32'(sb_if.load_use_stall), 32'(v.st));
        @(posedge clk);
        #1;
        chk({tag, " rs1_sel"}, 32'(sb_if.rs1_fwd_sel), 32'(v.s1));
        chk({tag, " rs2_sel"}, 32'(sb_if.rs2_fwd_sel), 32'(v.s2));
        chk({tag, " mask"}, sb_if.pending_mask, v.mask);
        chk({tag, " sb_err"}, 32'(sb_if.sb_err), 32'(v.err));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        drive(idl(0, 0, 32'h0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({tag, " rs1_sel"}, 32'(sb_if.rs1_fwd_sel), 32'(I));
        chk({tag, " rs2_sel"}, 32'(sb_if.rs2_fwd_sel), 32'(I));
        chk({tag, " mask"}, sb_if.pending_mask, 32'h0);
        chk({tag, " sb_err"}, 32'(sb_if.sb_err), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // lw x5 ; add x6,x5,x1
        tbl[0]  = mk(1,0,0, 0,0, 0,0, 5,1,1, 0,0, 0, I,I, 32'h20);
        tbl[1]  = mk(1,0,0, 5,1, 1,1, 6,1,0, 0,0, 1, I,I, 32'h20);
        tbl[2]  = mk(1,0,0, 5,1, 1,1, 6,1,0, 0,0, 0, W,I, 32'h60);
        tbl[3]  = idl(1,5, 32'h40);
        tbl[4]  = idl(0,0, 32'h40);
        tbl[5]  = idl(1,6, 32'h0);
        // add x5 ; sub x7,x5,x5
        tbl[6]  = mk(1,0,0, 1,1, 2,1, 5,1,0, 0,0, 0, I,I, 32'h20);
        tbl[7]  = mk(1,0,0, 5,1, 5,1, 7,1,0, 0,0, 0, E,E, 32'hA0);
        tbl[8]  = idl(0,0, 32'hA0);
        tbl[9]  = idl(1,5, 32'h80);
        tbl[10] = idl(1,7, 32'h0);
        // add x5 ; add x5 ; or x8,x5,x0
        tbl[11] = mk(1,0,0, 1,1, 2,1, 5,1,0, 0,0, 0, I,I, 32'h20);
        tbl[12] = mk(1,0,0, 1,1, 2,1, 5,1,0, 0,0, 0, I,I, 32'h20);
        tbl[13] = mk(1,0,0, 5,1, 0,1, 8,1,0, 0,0, 0, E,I, 32'h120);
        tbl[14] = idl(1,5, 32'h120);
        tbl[15] = idl(1,5, 32'h100);
        tbl[16] = idl(1,8, 32'h0);
        // addi x0,x1 ; add x1,x0,x0
        tbl[17] = mk(1,0,0, 1,1, 0,0, 0,1,0, 0,0, 0, I,I, 32'h0);
        tbl[18] = mk(1,0,0, 0,1, 0,1, 1,1,0, 0,0, 0, I,I, 32'h2);
        tbl[19] = idl(0,0, 32'h2);
        tbl[20] = idl(1,0, 32'h2);
        tbl[21] = idl(1,1, 32'h0);
        // flushed instructions never issue and never stall
        tbl[22] = mk(1,1,0, 1,1, 2,1, 9,1,0, 0,0, 0, I,I, 32'h0);
        tbl[23] = mk(1,0,0, 0,0, 0,0, 5,1,1, 0,0, 0, I,I, 32'h20);
        tbl[24] = mk(1,1,0, 1,1, 5,1, 6,1,0, 0,0, 0, I,I, 32'h20);
        tbl[25] = idl(0,0, 32'h20);
        tbl[26] = idl(1,5, 32'h0);
        // lw x5 ; add x6,x1,x5 (load-use on rs2)
        tbl[27] = mk(1,0,0, 0,0, 0,0, 5,1,1, 0,0, 0, I,I, 32'h20);
        tbl[28] = mk(1,0,0, 1,1, 5,1, 6,1,0, 0,0, 1, I,I, 32'h20);
        tbl[29] = mk(1,0,0, 1,1, 5,1, 6,1,0, 0,0, 0, I,W, 32'h60);
        tbl[30] = idl(1,5, 32'h40);
        tbl[31] = idl(0,0, 32'h40);
        tbl[32] = idl(1,6, 32'h0);

        drive(idl(0, 0, 32'h0));
        do_reset("reset");

        for (int i = 0; i < 33; i++)
            step(tbl[i], $sformatf("row%0d", i));

        // add x7 ; lw x5,0(x7) ; add x6,x5,x1 under a 4-cycle freeze
        step(mk(1,0,0, 1,1, 2,1, 7,1,0, 0,0, 0, I,I, 32'h80), "frz_add7");
        step(mk(1,0,0, 7,1, 0,0, 5,1,1, 0,0, 0, E,I, 32'hA0), "frz_lw5");
        for (int k = 0; k < 4; k++)
            step(mk(1,0,1, 5,1, 1,1, 6,1,0, 0,0, 1, E,I, 32'hA0), $sformatf("frz_hold%0d", k));
        step(mk(1,0,0, 5,1, 1,1, 6,1,0, 0,0, 1, I,I, 32'hA0), "frz_release");
        step(mk(1,0,0, 5,1, 1,1, 6,1,0, 1,7, 0, W,I, 32'h60), "frz_issue");
        step(idl(1,5, 32'h40), "frz_ret5");
        step(idl(0,0, 32'h40), "frz_idle");
        step(idl(1,6, 32'h0), "frz_ret6");

        // WB retires x9 while the WB slot holds x5
        step(mk(1,0,0, 1,1, 2,1, 5,1,0, 0,0, 0, I,I, 32'h20), "mis_add5");
        step(idl(0,0, 32'h20), "mis_idle0");
        step(idl(0,0, 32'h20), "mis_idle1");
        t = idl(1,9, 32'h20); t.err = 1'b1;
        step(t, "mis_ret9");
        t = idl(0,0, 32'h20); t.err = 1'b1;
        step(t, "mis_sticky0");
        step(t, "mis_sticky1");
        do_reset("mis_reset");

        // retirement while the WB slot is empty
        step(mk(1,0,0, 1,1, 2,1, 5,1,0, 0,0, 0, I,I, 32'h20), "emp_add5");
        t = idl(1,5, 32'h0); t.err = 1'b1;
        step(t, "emp_ret5");
        do_reset("emp_reset");

        // four writers of x5 in flight overflow the 2-bit counter
        for (int k = 0; k < 3; k++)
            step(mk(1,0,0, 1,1, 2,1, 5,1,0, 0,0, 0, I,I, 32'h20), $sformatf("ovf_add%0d", k));
        t = mk(1,0,0, 1,1, 2,1, 5,1,1, 0,0, 0, I,I, 32'h20); t.err = 1'b1;
        step(t, "ovf_lw");
        do_reset("ovf_reset");

        // in-flight load was dropped by reset: no stall, no forward
        step(mk(1,0,0, 5,1, 0,0, 6,1,0, 0,0, 0, I,I, 32'h40), "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
